as2650_wb_mailbox: RTL and testbench

- Wishbone classic responder to the management SoC's Wishbone initiator, on the wbs_* bus.
- Gives the host two byte FIFOs for messages: host-to-CPU (H2C) and CPU-to-host (C2H).
- Also gives the host control over the AS2650 core's reset.
- The CPU side is an 8-bit extended-I/O port strobe interface driven by the AS2650 core inside the user project area.

---
 rtl/as2650_mbox_pkg.sv | 40 ++++
 rtl/as2650_mbox_fifo.sv | 59 +++++
 rtl/as2650_wb_mailbox.sv | 184 ++++++++++++++++++
 tb/tb_as2650_wb_mailbox.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/as2650_mbox_pkg.sv
// Shared constants for the AS2650 Wishbone mailbox: register map, CTRL/STATUS bit positions
// and the STATUS word packing helper.
package as2650_mbox_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_H2C    = 3'd2;
  localparam logic [2:0] REG_C2H    = 3'd3;
  localparam logic [2:0] REG_CYCCNT = 3'd4;

  localparam int CTRL_CPU_RST = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam logic [1:0] CTRL_RST_VAL = 2'b01;

  localparam int ST_H2C_OVF = 16;
  localparam int ST_C2H_OVF = 17;
  localparam int ST_C2H_UDF = 18;
  localparam int ST_H2C_UDF = 19;

  // Counts arrive zero-extended to a byte; CPW never exceeds 7.
  function automatic logic [31:0] status_word(
    input logic [7:0] h2c_cnt,
    input logic [7:0] c2h_cnt,
    input logic       h2c_ovf,
    input logic       c2h_ovf,
    input logic       c2h_udf,
    input logic       h2c_udf
  );
    logic [31:0] s;
    s = '0;
    s[7:0]        = h2c_cnt;
    s[15:8]       = c2h_cnt;
    s[ST_H2C_OVF] = h2c_ovf;
    s[ST_C2H_OVF] = c2h_ovf;
    s[ST_C2H_UDF] = c2h_udf;
    s[ST_H2C_UDF] = h2c_udf;
    return s;
  endfunction

endpackage

// File: rtl/as2650_mbox_fifo.sv
// Byte-wide synchronous FIFO. A push is judged against the count before any same-cycle pop;
// o_ovf / o_udf pulse when a push or pop is refused.
module as2650_mbox_fifo #(
  parameter int DEPTH = 8,
  parameter int CPW   = $clog2(DEPTH) + 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_push,
  input  logic           i_pop,
  input  logic [7:0]     i_wdata,
  output logic [7:0]     o_rdata,
  output logic [CPW-1:0] o_count,
  output logic [CPW-1:0] o_count_nxt,
  output logic           o_full,
  output logic           o_empty,
  output logic           o_ovf,
  output logic           o_udf
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CPW-1:0] r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_full    = (r_count == CPW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_ovf     = i_push & o_full;
  assign o_udf     = i_pop & o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_comb begin
    o_count_nxt = r_count + CPW'(w_do_push) - CPW'(w_do_pop);
  end

  // Power-of-two depth lets the pointers wrap by simple overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= o_count_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/as2650_wb_mailbox.sv
// Wishbone mailbox between the management SoC and the AS2650 core: H2C/C2H byte FIFOs,
// CPU reset control and interrupts. Define AS2650_MBOX_CYCCNT_EN to add CYCCNT at offset 4.
module as2650_wb_mailbox
  import as2650_mbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CPW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        cpu_stb_i,
  input  logic        cpu_we_i,
  input  logic        cpu_addr_i,
  input  logic [7:0]  cpu_wdata_i,
  output logic [7:0]  cpu_rdata_o,
  output logic        cpu_rst_o,
  output logic        cpu_irq_o,
  output logic        host_irq_o
);

  logic           r_ack;
  logic [31:0]    r_dat;
  logic [7:0]     r_cpu_rdata;
  logic [1:0]     r_ctrl;
  logic           r_h2c_ovf, r_c2h_ovf, r_c2h_udf, r_h2c_udf;
  logic           r_cpu_irq, r_host_irq;

  logic           w_hit, w_req, w_wr, w_rd;
  logic [2:0]     w_off;
  logic [31:0]    w_rdata;
  logic [1:0]     w_ctrl_nxt;
  logic [3:0]     w_st_clr;
  logic           w_h2c_push, w_h2c_pop, w_c2h_push, w_c2h_pop;
  logic [7:0]     w_h2c_rdata, w_c2h_rdata;
  logic [CPW-1:0] w_h2c_cnt, w_c2h_cnt, w_h2c_cnt_nxt, w_c2h_cnt_nxt;
  logic           w_h2c_full, w_h2c_empty, w_c2h_full, w_c2h_empty;
  logic           w_h2c_ovf, w_h2c_udf, w_c2h_ovf, w_c2h_udf;
  logic           w_unused;

  // Classic Wishbone: a request is cyc & stb & address hit while no ack is outstanding.
  // It is accepted at the next edge, which raises ack for exactly one cycle, commits the
  // side effect and registers read data, so a held strobe yields one access per two cycles.
  assign w_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign w_req = w_hit & ~r_ack;
  assign w_wr  = w_req & wbs_we_i;
  assign w_rd  = w_req & ~wbs_we_i;
  assign w_off = wbs_adr_i[4:2];

  assign w_h2c_push = w_wr & (w_off == REG_H2C) & wbs_sel_i[0];
  assign w_c2h_pop  = w_rd & (w_off == REG_C2H);
  assign w_c2h_push = cpu_stb_i & ~cpu_addr_i & cpu_we_i;
  assign w_h2c_pop  = cpu_stb_i & ~cpu_addr_i & ~cpu_we_i;

  assign w_ctrl_nxt = (w_wr && w_off == REG_CTRL) ? wbs_dat_i[1:0] : r_ctrl;
  assign w_st_clr   = (w_wr && w_off == REG_STATUS) ? wbs_dat_i[ST_H2C_UDF:ST_H2C_OVF] : 4'b0;

  as2650_mbox_fifo #(.DEPTH(FIFO_DEPTH), .CPW(CPW)) u_h2c (
    .i_clk       (wb_clk_i),
    .i_rst       (wb_rst_i),
    .i_push      (w_h2c_push),
    .i_pop       (w_h2c_pop),
    .i_wdata     (wbs_dat_i[7:0]),
    .o_rdata     (w_h2c_rdata),
    .o_count     (w_h2c_cnt),
    .o_count_nxt (w_h2c_cnt_nxt),
    .o_full      (w_h2c_full),
    .o_empty     (w_h2c_empty),
    .o_ovf       (w_h2c_ovf),
    .o_udf       (w_h2c_udf)
  );

  as2650_mbox_fifo #(.DEPTH(FIFO_DEPTH), .CPW(CPW)) u_c2h (
    .i_clk       (wb_clk_i),
    .i_rst       (wb_rst_i),
    .i_push      (w_c2h_push),
    .i_pop       (w_c2h_pop),
    .i_wdata     (cpu_wdata_i),
    .o_rdata     (w_c2h_rdata),
    .o_count     (w_c2h_cnt),
    .o_count_nxt (w_c2h_cnt_nxt),
    .o_full      (w_c2h_full),
    .o_empty     (w_c2h_empty),
    .o_ovf       (w_c2h_ovf),
    .o_udf       (w_c2h_udf)
  );

`ifdef AS2650_MBOX_CYCCNT_EN
  logic [31:0] r_cyccnt;
  logic [31:0] w_cyccnt_nxt;

  always_comb begin
    w_cyccnt_nxt = r_ctrl[CTRL_CPU_RST] ? r_cyccnt : r_cyccnt + 32'd1;
    if (w_wr && w_off == REG_CYCCNT) begin
      for (int b = 0; b < 4; b++) begin
        w_cyccnt_nxt[8*b +: 8] = wbs_sel_i[b] ? wbs_dat_i[8*b +: 8] : r_cyccnt[8*b +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_cyccnt <= '0;
    else          r_cyccnt <= w_cyccnt_nxt;
  end
`endif

  always_comb begin
    w_rdata = '0;
    case (w_off)
      REG_CTRL:   w_rdata = {30'b0, r_ctrl};
      REG_STATUS: w_rdata = status_word(8'(w_h2c_cnt), 8'(w_c2h_cnt),
                                        r_h2c_ovf, r_c2h_ovf, r_c2h_udf, r_h2c_udf);
      REG_C2H:    w_rdata = {24'b0, (w_c2h_empty ? 8'h00 : w_c2h_rdata)};
`ifdef AS2650_MBOX_CYCCNT_EN
      REG_CYCCNT: w_rdata = r_cyccnt;
`endif
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : 32'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ctrl    <= CTRL_RST_VAL;
      r_h2c_ovf <= 1'b0;
      r_c2h_ovf <= 1'b0;
      r_c2h_udf <= 1'b0;
      r_h2c_udf <= 1'b0;
    end else begin
      r_ctrl    <= w_ctrl_nxt;
      // A new event in the same cycle as a clear wins, so no event is lost.
      r_h2c_ovf <= (r_h2c_ovf & ~w_st_clr[0]) | w_h2c_ovf;
      r_c2h_ovf <= (r_c2h_ovf & ~w_st_clr[1]) | w_c2h_ovf;
      r_c2h_udf <= (r_c2h_udf & ~w_st_clr[2]) | w_c2h_udf;
      r_h2c_udf <= (r_h2c_udf & ~w_st_clr[3]) | w_h2c_udf;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cpu_rdata <= '0;
    end else if (cpu_stb_i && !cpu_we_i) begin
      if (cpu_addr_i) r_cpu_rdata <= {w_h2c_empty, w_c2h_full, 6'b0};
      else            r_cpu_rdata <= w_h2c_empty ? 8'h00 : w_h2c_rdata;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_cpu_irq  <= 1'b0;
      r_host_irq <= 1'b0;
    end else begin
      r_cpu_irq  <= (w_h2c_cnt_nxt != '0);
      r_host_irq <= (w_c2h_cnt_nxt != '0) & w_ctrl_nxt[CTRL_IRQ_EN];
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_dat;
  assign cpu_rdata_o = r_cpu_rdata;
  assign cpu_rst_o   = r_ctrl[CTRL_CPU_RST];
  assign cpu_irq_o   = r_cpu_irq;
  assign host_irq_o  = r_host_irq;

  assign w_unused = ^{wbs_adr_i[1:0], wbs_dat_i, wbs_sel_i, w_h2c_full};

endmodule

// File: tb/tb_as2650_wb_mailbox.sv
// Scoreboard bench for as2650_wb_mailbox: queue-based reference model of both FIFOs and
// the CSRs, directed scenarios followed by a randomized mix of host and CPU operations.
module tb_as2650_wb_mailbox;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        cpu_stb_i = 1'b0, cpu_we_i = 1'b0, cpu_addr_i = 1'b0;
  logic [7:0]  cpu_wdata_i = '0;
  logic [7:0]  cpu_rdata_o;
  logic        cpu_rst_o, cpu_irq_o, host_irq_o;

  always #5 clk = ~clk;

  as2650_wb_mailbox #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .cpu_stb_i(cpu_stb_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
    .cpu_rst_o(cpu_rst_o), .cpu_irq_o(cpu_irq_o), .host_irq_o(host_irq_o)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] wb_exp_q[$];
  bit          wb_chk_q[$];
  logic [7:0]  cpu_exp_q[$];
  logic [31:0] cap_q[$];
  bit          capture_mode = 0;

  logic [7:0]  h2c_m[$];
  logic [7:0]  c2h_m[$];
  logic        m_h2c_ovf, m_c2h_ovf, m_c2h_udf, m_h2c_udf;
  logic [1:0]  m_ctrl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  task automatic model_reset();
    h2c_m.delete();
    c2h_m.delete();
    m_h2c_ovf = 0; m_c2h_ovf = 0; m_c2h_udf = 0; m_h2c_udf = 0;
    m_ctrl = 2'b01;
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[7:0]  = 8'(h2c_m.size());
    s[15:8] = 8'(c2h_m.size());
    s[16] = m_h2c_ovf;
    s[17] = m_c2h_ovf;
    s[18] = m_c2h_udf;
    s[19] = m_h2c_udf;
    return s;
  endfunction

  // Monitor
  logic cpu_rd_d = 1'b0;
  always @(posedge clk) cpu_rd_d <= cpu_stb_i & ~cpu_we_i;

  always @(negedge clk) begin
    if (wbs_ack_o) begin
      if (capture_mode) begin
        cap_q.push_back(wbs_dat_o);
      end else if (wb_exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL wb_unexpected_ack: got ack=1 expected no ack at %0t", $time);
      end else begin
        logic [31:0] e;
        bit          c;
        e = wb_exp_q.pop_front();
        c = wb_chk_q.pop_front();
        if (c) check("wb_rdata", wbs_dat_o, e);
      end
    end
    if (cpu_rd_d) begin
      if (cpu_exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL cpu_unexpected_read: got %h with empty queue", cpu_rdata_o);
      end else begin
        check("cpu_rdata", {24'b0, cpu_rdata_o}, {24'b0, cpu_exp_q.pop_front()});
      end
    end
  end

  // Drivers
  task automatic wb_io(input logic we, input logic [2:0] off, input logic [31:0] wdat,
                       input logic [3:0] sel, input logic [31:0] exp, input bit chk);
    int  i;
    bit  got;
    wb_exp_q.push_back(exp);
    wb_chk_q.push_back(chk);
    @(posedge clk); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_sel_i = sel;
    wbs_adr_i = {BASE[31:5], off, 2'b00}; wbs_dat_i = wdat;
    i = 0; got = 0;
    while (!got && i < 8) begin
      @(negedge clk);
      got = wbs_ack_o;
      i++;
    end
    #1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL wb_ack_timeout: got no ack expected ack within 8 cycles, off %0d", off);
      void'(wb_exp_q.pop_back());
      void'(wb_chk_q.pop_back());
    end
  endtask

  task automatic cpu_io(input logic we, input logic addr, input logic [7:0] wd);
    @(posedge clk); #1;
    cpu_stb_i = 1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
    @(posedge clk); #1;
    cpu_stb_i = 0; cpu_we_i = 0;
  endtask

  // Model-level operations
  task automatic host_push(input logic [7:0] b, input logic sel0);
    if (sel0) begin
      if (h2c_m.size() == DEPTH) m_h2c_ovf = 1;
      else h2c_m.push_back(b);
    end
    wb_io(1, 3'd2, {$urandom} & 32'hFFFF_FF00 | {24'b0, b}, {3'($urandom), sel0}, 0, 0);
  endtask

  task automatic host_pop();
    logic [31:0] e;
    if (c2h_m.size() == 0) begin e = 0; m_c2h_udf = 1; end
    else e = {24'b0, c2h_m.pop_front()};
    wb_io(0, 3'd3, 0, 4'hF, e, 1);
  endtask

  task automatic host_status();
    wb_io(0, 3'd1, 0, 4'hF, m_status(), 1);
  endtask

  task automatic host_clear(input logic [3:0] m);
    if (m[0]) m_h2c_ovf = 0;
    if (m[1]) m_c2h_ovf = 0;
    if (m[2]) m_c2h_udf = 0;
    if (m[3]) m_h2c_udf = 0;
    wb_io(1, 3'd1, {12'b0, m, 16'b0}, 4'hF, 0, 0);
  endtask

  task automatic host_ctrl_wr(input logic [1:0] v);
    m_ctrl = v;
    wb_io(1, 3'd0, {30'b0, v}, 4'hF, 0, 0);
  endtask

  task automatic host_ctrl_rd();
    wb_io(0, 3'd0, 0, 4'hF, {30'b0, m_ctrl}, 1);
  endtask

  task automatic cpu_push(input logic [7:0] b);
    if (c2h_m.size() == DEPTH) m_c2h_ovf = 1;
    else c2h_m.push_back(b);
    cpu_io(1, 0, b);
  endtask

  task automatic cpu_pop();
    if (h2c_m.size() == 0) begin cpu_exp_q.push_back(8'h00); m_h2c_udf = 1; end
    else cpu_exp_q.push_back(h2c_m.pop_front());
    cpu_io(0, 0, 0);
  endtask

  task automatic cpu_status();
    cpu_exp_q.push_back({h2c_m.size() == 0, c2h_m.size() == DEPTH, 6'b0});
    cpu_io(0, 1, 0);
  endtask

  task automatic check_side();
    @(negedge clk);
    check("cpu_irq", {31'b0, cpu_irq_o}, {31'b0, h2c_m.size() != 0});
    check("host_irq", {31'b0, host_irq_o}, {31'b0, (c2h_m.size() != 0) && m_ctrl[1]});
    check("cpu_rst", {31'b0, cpu_rst_o}, {31'b0, m_ctrl[0]});
  endtask

  initial begin
    logic [5:0] pat;
    int         acks;

    model_reset();
    repeat (3) @(posedge clk);
    #1 wb_rst_i = 0;
    @(negedge clk);
    check("rst_ack", {31'b0, wbs_ack_o}, 0);
    check("rst_dat", wbs_dat_o, 0);
    check("rst_cpu_rdata", {24'b0, cpu_rdata_o}, 0);
    check("rst_cpu_rst", {31'b0, cpu_rst_o}, 1);
    check("rst_irqs", {30'b0, cpu_irq_o, host_irq_o}, 0);
    host_ctrl_rd();
    host_status();

    // H2C basic flow
    host_push(8'hA1, 1);
    check_side();
    host_push(8'hB2, 1);
    cpu_pop();
    cpu_pop();
    check_side();

    // H2C overflow and W1C
    for (int i = 0; i < 9; i++) host_push(8'(8'h10 + i), 1);
    host_status();
    host_clear(4'b0001);
    host_status();
    for (int i = 0; i < 8; i++) cpu_pop();
    cpu_pop();
    host_status();
    host_clear(4'b1000);

    // C2H flow with irq enabled
    host_ctrl_wr(2'b10);
    cpu_push(8'h5C);
    check_side();
    host_pop();
    check_side();
    host_pop();
    host_status();
    host_clear(4'b0100);

    // Simultaneous CPU pop and host push at count 3
    for (int i = 0; i < 3; i++) host_push(8'(8'hC0 + i), 1);
    cpu_exp_q.push_back(h2c_m.pop_front());
    h2c_m.push_back(8'hD4);
    wb_exp_q.push_back(0); wb_chk_q.push_back(0);
    @(posedge clk); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF;
    wbs_adr_i = {BASE[31:5], 3'd2, 2'b00}; wbs_dat_i = 32'hD4;
    cpu_stb_i = 1; cpu_we_i = 0; cpu_addr_i = 0;
    @(posedge clk); #1;
    cpu_stb_i = 0;
    @(negedge clk); #1;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    host_status();
    for (int i = 0; i < 3; i++) cpu_pop();
    cpu_status();

    // Held strobe: one access per two cycles
    for (int i = 0; i < 3; i++) begin wb_exp_q.push_back({30'b0, m_ctrl}); wb_chk_q.push_back(1); end
    @(posedge clk); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = {BASE[31:5], 3'd0, 2'b00};
    for (int i = 0; i < 6; i++) begin @(negedge clk); pat[i] = wbs_ack_o; end
    #1 wbs_cyc_i = 0; wbs_stb_i = 0;
    check("held_stb_ack_pattern", {26'b0, pat}, 32'b101010);

    // Non-matching address gets no ack
    @(posedge clk); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_adr_i = BASE + 32'h100;
    acks = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); acks += int'(wbs_ack_o); end
    #1 wbs_cyc_i = 0; wbs_stb_i = 0;
    check("nomatch_acks", acks, 0);

    // Reserved offsets
    wb_io(1, 3'd5, $urandom, 4'hF, 0, 0);
    wb_io(0, 3'd6, 0, 4'hF, 0, 1);
    wb_io(0, 3'd2, 0, 4'hF, 0, 1);

`ifdef AS2650_MBOX_CYCCNT_EN
    host_ctrl_wr(2'b01);
    wb_io(1, 3'd4, 32'hDEAD_BEEF, 4'hF, 0, 0);
    wb_io(0, 3'd4, 0, 4'hF, 32'hDEAD_BEEF, 1);
    wb_io(1, 3'd4, 32'h1234_5611, 4'b0001, 0, 0);
    wb_io(0, 3'd4, 0, 4'hF, 32'hDEAD_BE11, 1);
    host_ctrl_wr(2'b00);
    capture_mode = 1;
    @(posedge clk); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = {BASE[31:5], 3'd4, 2'b00};
    repeat (12) @(negedge clk);
    #1 wbs_cyc_i = 0; wbs_stb_i = 0;
    @(negedge clk);
    capture_mode = 0;
    check("cyccnt_captures", cap_q.size(), 6);
    if (cap_q.size() == 6) check("cyccnt_delta10", cap_q[5] - cap_q[0], 32'd10);
`else
    wb_io(1, 3'd4, 32'hFFFF_FFFF, 4'hF, 0, 0);
    wb_io(0, 3'd4, 0, 4'hF, 0, 1);
`endif

    // Randomized mix
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1: host_push(8'($urandom), ($urandom_range(0, 7) != 0));
        2:    host_pop();
        3:    host_status();
        4:    host_clear(4'($urandom));
        5, 6: cpu_push(8'($urandom));
        7:    cpu_pop();
        8:    cpu_status();
        default: if ($urandom_range(0, 1) == 0) host_ctrl_wr(2'($urandom));
                 else host_ctrl_rd();
      endcase
      if (n % 10 == 0) check_side();
    end

    // Reset during an acked read with both FIFOs at 5
    host_ctrl_wr(2'b10);
    while (h2c_m.size() < 5) host_push(8'($urandom), 1);
    while (h2c_m.size() > 5) cpu_pop();
    while (c2h_m.size() < 5) cpu_push(8'($urandom));
    while (c2h_m.size() > 5) host_pop();
    check_side();
    wb_exp_q.push_back({24'b0, c2h_m.pop_front()}); wb_chk_q.push_back(1);
    @(posedge clk); #1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = {BASE[31:5], 3'd3, 2'b00};
    @(posedge clk); #1;
    wb_rst_i = 1; wbs_cyc_i = 0; wbs_stb_i = 0;
    @(posedge clk); #1;
    wb_rst_i = 0;
    model_reset();
    @(negedge clk);
    check("rst2_ack", {31'b0, wbs_ack_o}, 0);
    check("rst2_cpu_rst", {31'b0, cpu_rst_o}, 1);
    check("rst2_irqs", {30'b0, cpu_irq_o, host_irq_o}, 0);
    host_status();
    host_ctrl_rd();
    cpu_pop();
    host_status();

    repeat (3) @(negedge clk);
    check("wb_queue_drained", wb_exp_q.size(), 0);
    check("cpu_queue_drained", cpu_exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2 ms");
    $fatal(1);
  end

endmodule
